// File: rtl/add2_bist_ctrl.sv
// BIST controller for the add2 CUT: LFSR stimulus, MISR compaction, golden compare.
// Run latency is 1 + NUM_PAT*(SETTLE_CYC+1) + 1 cycles; start is accepted only in IDLE/DONE, with no queueing.
module add2_bist_ctrl #(
  parameter int         NUM_PAT    = 31,
  parameter logic [4:0] LFSR_SEED  = 5'b00001,
  parameter int         SETTLE_CYC = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] golden_sig,
  input  logic [2:0] cut_out,
  output logic [4:0] cut_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] signature,
  output logic [4:0] pat_cnt
);

  typedef enum logic [2:0] {IDLE, SEED, APPLY, CAPTURE, COMPARE, DONE} state_t;

  localparam logic [4:0] NUM_PAT_L   = 5'(NUM_PAT);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

  state_t     state;
  logic [4:0] lfsr;
  logic [7:0] misr;
  logic [3:0] settle;
  logic [4:0] lfsr_next;
  logic [7:0] misr_next;

  assign lfsr_next = {lfsr[3:0], lfsr[4] ^ lfsr[1]};
  assign misr_next = {misr[6:0], misr[7] ^ misr[5] ^ misr[4] ^ misr[3]} ^ {5'b0, cut_out};
  assign signature = misr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      lfsr    <= LFSR_SEED;
      misr    <= 8'h00;
      pat_cnt <= 5'd0;
      settle  <= 4'd0;
      cut_in  <= 5'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cut_in <= 5'd0;
          if (start) begin
            state <= SEED;
            busy  <= 1'b1;
          end
        end
        SEED: begin
          lfsr    <= LFSR_SEED;
          misr    <= 8'h00;
          pat_cnt <= 5'd0;
          settle  <= 4'd0;
          cut_in  <= LFSR_SEED;
          state   <= APPLY;
        end
        APPLY: begin
          if (settle == SETTLE_LAST) begin
            settle <= 4'd0;
            state  <= CAPTURE;
          end else begin
            settle <= settle + 4'd1;
          end
        end
        CAPTURE: begin
          misr    <= misr_next;
          lfsr    <= lfsr_next;
          pat_cnt <= pat_cnt + 5'd1;
          // cut_in is registered, so it is loaded with the next pattern on this same edge
          if (pat_cnt + 5'd1 == NUM_PAT_L) begin
            cut_in <= 5'd0;
            state  <= COMPARE;
          end else begin
            cut_in <= lfsr_next;
            state  <= APPLY;
          end
        end
        COMPARE: begin
          pass  <= (misr == golden_sig);
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= DONE;
        end
        DONE: begin
          cut_in <= 5'd0;
          // done/pass drop on the accepting edge so they are already low during SEED
          if (start) begin
            state <= SEED;
            busy  <= 1'b1;
            done  <= 1'b0;
            pass  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_add2_bist_ctrl.sv
// Directed bench for add2_bist_ctrl with a behavioural add2 CUT and optional injected faults.
module tb_add2_bist_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       start4 = 1'b0;
  logic [7:0] golden_sig = 8'h00;
  logic [7:0] golden4 = 8'h00;
  logic [4:0] cut_in, cut_in4, pat_cnt, pat_cnt4;
  logic [2:0] cut_out, cut_out4;
  logic       busy, done, pass, busy4, done4, pass4;
  logic [7:0] signature, signature4;
  int         mode = 0;
  int         vecs = 0;
  int         errs = 0;
  logic [4:0] exp_pat [10];

  always #5 clk = ~clk;

  // add2: {N2,N1} + {N4,N3} + N5; mode 1 = outputs tied low, mode 2 = N50 stuck-at-0
  function automatic logic [2:0] cut_model(input logic [4:0] in, input int m);
    logic [2:0] s;
    s = {1'b0, in[1:0]} + {1'b0, in[3:2]} + {2'b0, in[4]};
    if (m == 1) s = 3'b000;
    else if (m == 2) s = s & 3'b110;
    return s;
  endfunction

  function automatic logic [7:0] ref_sig(input int npat, input int m);
    logic [4:0] l;
    logic [7:0] r;
    l = 5'h01;
    r = 8'h00;
    for (int p = 0; p < npat; p++) begin
      r = {r[6:0], r[7] ^ r[5] ^ r[4] ^ r[3]} ^ {5'b0, cut_model(l, m)};
      l = {l[3:0], l[4] ^ l[1]};
    end
    return r;
  endfunction

  assign cut_out  = cut_model(cut_in, mode);
  assign cut_out4 = cut_model(cut_in4, 0);

  add2_bist_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .golden_sig(golden_sig), .cut_out(cut_out),
    .cut_in(cut_in), .busy(busy), .done(done), .pass(pass), .signature(signature), .pat_cnt(pat_cnt)
  );

  add2_bist_ctrl #(.NUM_PAT(4), .LFSR_SEED(5'b00001), .SETTLE_CYC(3)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .golden_sig(golden4), .cut_out(cut_out4),
    .cut_in(cut_in4), .busy(busy4), .done(done4), .pass(pass4), .signature(signature4), .pat_cnt(pat_cnt4)
  );

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    vecs++; if (cut_in !== 5'd0) begin errs++; $display("FAIL reset_cut_in: got %h want 00", cut_in); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", busy); end
    vecs++; if (done !== 1'b0) begin errs++; $display("FAIL reset_done: got %b want 0", done); end
    vecs++; if (pass !== 1'b0) begin errs++; $display("FAIL reset_pass: got %b want 0", pass); end
    vecs++; if (signature !== 8'h00) begin errs++; $display("FAIL reset_sig: got %h want 00", signature); end
    vecs++; if (pat_cnt !== 5'd0) begin errs++; $display("FAIL reset_pat_cnt: got %0d want 0", pat_cnt); end
    vecs++; if (done4 !== 1'b0 || cut_in4 !== 5'd0) begin errs++; $display("FAIL reset_dut4: done %b cut_in %h want 0/00", done4, cut_in4); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vecs++; if (cut_in !== 5'd0 || busy !== 1'b0) begin errs++; $display("FAIL idle_hold: cut_in %h busy %b want 00/0", cut_in, busy); end
  endtask

  task automatic test_good_run();
    int k;
    mode = 0;
    golden_sig = ref_sig(31, 0);
    pulse_start();
    vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL seed_busy: got %b want 1", busy); end
    k = 0;
    while (!done && k < 200) begin
      @(posedge clk); #1;
      k++;
      if (k >= 1 && k <= 20) begin
        vecs++;
        if (cut_in !== exp_pat[(k-1)/2]) begin
          errs++; $display("FAIL cut_in_seq cycle %0d: got %h want %h", k, cut_in, exp_pat[(k-1)/2]);
        end
      end
    end
    vecs++; if (k != 64) begin errs++; $display("FAIL run_len: got %0d want 64", k); end
    vecs++; if (pat_cnt !== 5'd31) begin errs++; $display("FAIL good_pat_cnt: got %0d want 31", pat_cnt); end
    vecs++; if (pass !== 1'b1) begin errs++; $display("FAIL good_pass: got %b want 1", pass); end
    vecs++; if (signature !== golden_sig) begin errs++; $display("FAIL good_sig: got %h want %h", signature, golden_sig); end
    vecs++; if (busy !== 1'b0 || cut_in !== 5'd0) begin errs++; $display("FAIL done_outputs: busy %b cut_in %h want 0/00", busy, cut_in); end
  endtask

  task automatic test_zero_cut();
    int k;
    mode = 1;
    golden_sig = 8'h00;
    pulse_start();
    wait_done(k);
    vecs++; if (signature !== 8'h00) begin errs++; $display("FAIL zero_sig: got %h want 00", signature); end
    vecs++; if (pass !== 1'b1) begin errs++; $display("FAIL zero_pass: got %b want 1", pass); end
    golden_sig = 8'h01;
    pulse_start();
    wait_done(k);
    vecs++; if (done !== 1'b1) begin errs++; $display("FAIL zero_bad_done: got %b want 1", done); end
    vecs++; if (pass !== 1'b0) begin errs++; $display("FAIL zero_bad_pass: got %b want 0", pass); end
  endtask

  task automatic test_stuck_fault();
    int k;
    logic [7:0] faulty;
    mode = 2;
    golden_sig = ref_sig(31, 0);
    faulty = ref_sig(31, 2);
    pulse_start();
    wait_done(k);
    vecs++; if (pass !== 1'b0) begin errs++; $display("FAIL stuck_pass: got %b want 0", pass); end
    vecs++; if (signature !== faulty) begin errs++; $display("FAIL stuck_sig: got %h want %h", signature, faulty); end
    vecs++; if (signature === golden_sig) begin errs++; $display("FAIL stuck_alias: got %h want not %h", signature, golden_sig); end
  endtask

  task automatic test_short_run();
    int k;
    golden4 = 8'h00;
    start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    k = 0;
    while (!done4 && k < 200) begin
      @(posedge clk); #1;
      k++;
      if (k >= 1 && k <= 16) begin
        vecs++;
        if (cut_in4 !== exp_pat[(k-1)/4]) begin
          errs++; $display("FAIL short_cut_in cycle %0d: got %h want %h", k, cut_in4, exp_pat[(k-1)/4]);
        end
      end
    end
    vecs++; if (k != 18) begin errs++; $display("FAIL short_len: got %0d want 18", k); end
    vecs++; if (pat_cnt4 !== 5'd4) begin errs++; $display("FAIL short_pat_cnt: got %0d want 4", pat_cnt4); end
    vecs++; if (signature4 !== 8'h00) begin errs++; $display("FAIL short_sig: got %h want 00", signature4); end
    vecs++; if (pass4 !== 1'b1 || busy4 !== 1'b0) begin errs++; $display("FAIL short_pass: pass %b busy %b want 1/0", pass4, busy4); end
  endtask

  task automatic test_start_ignored();
    int k;
    mode = 0;
    golden_sig = ref_sig(31, 0);
    pulse_start();
    k = 0;
    while (!done && k < 200) begin
      @(posedge clk); #1;
      k++;
      start = (k == 5);
    end
    start = 1'b0;
    vecs++; if (k != 64) begin errs++; $display("FAIL ignored_len: got %0d want 64", k); end
    vecs++; if (signature !== golden_sig || pass !== 1'b1) begin errs++; $display("FAIL ignored_sig: got %h/%b want %h/1", signature, pass, golden_sig); end
  endtask

  task automatic test_back_to_back();
    int k;
    logic [7:0] prev;
    prev = signature;
    pulse_start();
    vecs++; if (done !== 1'b0 || pass !== 1'b0 || busy !== 1'b1) begin
      errs++; $display("FAIL restart_clear: done %b pass %b busy %b want 0/0/1", done, pass, busy);
    end
    wait_done(k);
    vecs++; if (k != 64) begin errs++; $display("FAIL restart_len: got %0d want 64", k); end
    vecs++; if (signature !== prev || pass !== 1'b1) begin errs++; $display("FAIL restart_sig: got %h/%b want %h/1", signature, pass, prev); end
  endtask

  task automatic test_reset_mid();
    int k;
    mode = 0;
    golden_sig = ref_sig(31, 0);
    pulse_start();
    for (k = 0; k < 20; k++) begin
      @(posedge clk); #1;
    end
    vecs++; if (cut_in !== 5'h1B || pat_cnt !== 5'd9) begin errs++; $display("FAIL mid_state: cut_in %h pat_cnt %0d want 1b/9", cut_in, pat_cnt); end
    #1 rst_n = 1'b0;
    #1;
    vecs++; if (cut_in !== 5'd0 || busy !== 1'b0) begin errs++; $display("FAIL abort_cut_busy: cut_in %h busy %b want 00/0", cut_in, busy); end
    vecs++; if (signature !== 8'h00 || pat_cnt !== 5'd0) begin errs++; $display("FAIL abort_sig_cnt: sig %h pat_cnt %0d want 00/0", signature, pat_cnt); end
    vecs++; if (done !== 1'b0 || pass !== 1'b0) begin errs++; $display("FAIL abort_done_pass: done %b pass %b want 0/0", done, pass); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vecs++; if (cut_in !== 5'd0 || busy !== 1'b0 || done !== 1'b0) begin
      errs++; $display("FAIL post_reset_idle: cut_in %h busy %b done %b want 00/0/0", cut_in, busy, done);
    end
    pulse_start();
    wait_done(k);
    vecs++; if (k != 64 || signature !== golden_sig || pass !== 1'b1) begin
      errs++; $display("FAIL post_reset_run: len %0d sig %h pass %b want 64/%h/1", k, signature, pass, golden_sig);
    end
  endtask

  initial begin
    exp_pat = '{5'h01, 5'h02, 5'h05, 5'h0A, 5'h15, 5'h0B, 5'h17, 5'h0E, 5'h1D, 5'h1B};
    test_reset();
    test_good_run();
    test_zero_cut();
    test_stuck_fault();
    test_short_run();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/add2_bist_ctrl.md
Name: add2_bist_ctrl

Overview:
Built-in self-test controller for the 5-input/3-output add2 combinational CUT (inputs N1..N5, outputs N50..N52).
- Generates pseudo-random patterns with a 5-bit LFSR and drives them onto the CUT inputs.
- Waits a programmable settle time, then compacts each 3-bit CUT response into an 8-bit MISR.
- After NUM_PAT patterns, compares the signature against a golden value and reports pass/fail.
- Replaces file-driven pattern application for on-chip test of the adder.

Parameters:
NUM_PAT, 31, number of patterns applied per run (1..31; 31 = full LFSR period)
LFSR_SEED, 5'b00001, initial LFSR state (must be non-zero)
SETTLE_CYC, 1, clock cycles a pattern is held before capture (1..15)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle run request; honoured only in IDLE or DONE
golden_sig  input  8  expected MISR signature; sampled in COMPARE
cut_out  input  3  CUT response {N52,N51,N50} = cut_out[2:0]
cut_in  output  5  CUT stimulus {N5,N4,N3,N2,N1} = cut_in[4:0]
busy  output  1  high from SEED through COMPARE
done  output  1  run finished; held until the next accepted start
pass  output  1  signature == golden_sig; valid while done=1
signature  output  8  current MISR contents
pat_cnt  output  5  number of patterns captured so far

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, lfsr=LFSR_SEED, misr=8'h00, pat_cnt=0, settle counter=0.
  - cut_in=0, busy=0, done=0, pass=0, signature=0.
  - Reset asserted mid-run aborts immediately. No partial result is kept.
- States: IDLE, SEED, APPLY, CAPTURE, COMPARE, DONE.
- IDLE: cut_in=0. start=1 -> SEED.
- SEED (1 cycle): lfsr<=LFSR_SEED, misr<=0, pat_cnt<=0, done<=0, pass<=0. -> APPLY.
- APPLY:
  - cut_in=lfsr.
  - The settle counter counts SETTLE_CYC cycles, then -> CAPTURE.
- CAPTURE (1 cycle): cut_in stays = lfsr. On the clock edge:
  - misr <= {misr[6:0], misr[7]^misr[5]^misr[4]^misr[3]} ^ {5'b0, cut_out}.
  - lfsr <= {lfsr[3:0], lfsr[4]^lfsr[1]}.
  - pat_cnt <= pat_cnt+1.
  - Next state: if pat_cnt+1 == NUM_PAT -> COMPARE, else -> APPLY.
- COMPARE (1 cycle): pass <= (misr == golden_sig), done <= 1. -> DONE.
- DONE:
  - cut_in=0. done, pass, signature and pat_cnt are held.
  - start=1 -> SEED: done and pass clear in SEED, and a fresh run begins.
- start is ignored in SEED, APPLY, CAPTURE and COMPARE. There is no queueing.
- LFSR sequence from 5'h01: 01, 02, 05, 0A, 15, 0B, ... Period is 31; the all-zero state is never reached from a non-zero seed.
- Run length: 1 + NUM_PAT*(SETTLE_CYC+1) + 1 cycles from SEED entry to DONE entry. The default is 64.
- signature mirrors misr combinationally from the register, in every state.
- busy=1 exactly in SEED, APPLY, CAPTURE and COMPARE.

Test Plan:
- Reset, then start pulse with defaults and a correct add2 CUT connected:
  - cut_in sequence is 01, 02, 05, 0A, 15, 0B, ..., with each value held 2 cycles.
  - done rises 64 cycles after SEED entry and pat_cnt=31.
  - pass=1 when golden_sig equals the reference-model signature.
- cut_out tied to 3'b000, golden_sig=8'h00 -> signature=8'h00, pass=1. Same stimulus with golden_sig=8'h01 -> pass=0, done=1.
- CUT with N50 stuck-at-0 and the fault-free golden_sig -> pass=0. signature differs from golden and matches the faulty reference model.
- NUM_PAT=4, SETTLE_CYC=3:
  - exactly 4 patterns (01, 02, 05, 0A), each held 4 cycles, then 1 capture cycle.
  - done after 1+4*4+1=18 cycles, pat_cnt=4.
- start pulsed during APPLY -> ignored; run length unchanged. start pulsed in DONE -> done/pass clear next cycle and the run repeats with the identical signature.
- rst_n dropped during the 10th CAPTURE -> all outputs return to reset values asynchronously. After release, IDLE with cut_in=0 until the next start.
